// File: rtl/vga_timing_gen_param_if.sv
// Pixel-side bundle of the VGA timing generator: box position requests in,
// counter position, colour, sync, data-enable and frame pulse out.
interface vga_timing_gen_param_if #(
  parameter int COLOR_W = 4
);
  logic               pix_ce;
  logic [9:0]         x_move;
  logic [9:0]         y_move;
  logic [11:0]        pix_x;
  logic [11:0]        pix_y;
  logic [COLOR_W-1:0] po_vga_r;
  logic [COLOR_W-1:0] po_vga_g;
  logic [COLOR_W-1:0] po_vga_b;
  logic               po_h_sync;
  logic               po_v_sync;
  logic               po_de;
  logic               frame_start;

  // Handshake: there is no valid/ready pair; pix_ce qualifies every clock
  // and all outputs are valid on every sclk, advancing only when pix_ce is high.
  modport master (
    input  pix_ce, x_move, y_move,
    output pix_x, pix_y, po_vga_r, po_vga_g, po_vga_b,
           po_h_sync, po_v_sync, po_de, frame_start
  );

  modport slave (
    output pix_ce, x_move, y_move,
    input  pix_x, pix_y, po_vga_r, po_vga_g, po_vga_b,
           po_h_sync, po_v_sync, po_de, frame_start
  );
endinterface

// File: rtl/vga_timing_gen_param.sv
// Parametrised VGA timing generator with a frame-latched, clamped box overlay.
// Counters form stage 0; two registered stages bring everything to the pins aligned.
module vga_timing_gen_param #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   COLOR_W  = 4,
  parameter int   BOX_SIZE = 32,
  parameter logic [3*COLOR_W-1:0] BG_COLOR  = 12'h00F,
  parameter logic [3*COLOR_W-1:0] BOX_COLOR = 12'hF00
) (
  input  logic sclk,
  input  logic rst,
  vga_timing_gen_param_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] BOX    = 12'(BOX_SIZE);
  localparam logic [11:0] X_MAX  = 12'(H_ACTIVE - BOX_SIZE);
  localparam logic [11:0] Y_MAX  = 12'(V_ACTIVE - BOX_SIZE);

  logic [11:0] h_cnt, v_cnt;
  logic [11:0] box_x, box_y;
  logic [11:0] x_req, y_req, x_clamp, y_clamp;
  logic        de0, hs0, vs0, in_box0, fs0, frame_end;
  logic        de1, hs1, vs1, in_box1, fs1;
  logic [3*COLOR_W-1:0] rgb;
  logic        h_sync, v_sync, de, fs;

  // Stage 0: decoded straight from the counters
  assign de0       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs0       = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs0       = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign fs0       = (h_cnt == 12'd0) && (v_cnt == 12'd0);
  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign in_box0   = (h_cnt >= box_x) && (h_cnt < box_x + BOX) &&
                     (v_cnt >= box_y) && (v_cnt < box_y + BOX);

  // Requests are clamped so the box never leaves the visible area
  assign x_req   = {2'b00, vga.x_move};
  assign y_req   = {2'b00, vga.y_move};
  assign x_clamp = (x_req > X_MAX) ? X_MAX : x_req;
  assign y_clamp = (y_req > Y_MAX) ? Y_MAX : y_req;

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
      box_x <= '0;
      box_y <= '0;
    end else if (vga.pix_ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
      end else begin
        h_cnt <= h_cnt + 12'd1;
      end
      // Position only moves at the frame boundary, so a frame is never torn
      if (frame_end) begin
        box_x <= x_clamp;
        box_y <= y_clamp;
      end
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      de1     <= 1'b0;
      hs1     <= 1'b0;
      vs1     <= 1'b0;
      in_box1 <= 1'b0;
      fs1     <= 1'b0;
      rgb     <= '0;
      h_sync  <= ~HS_POL;
      v_sync  <= ~VS_POL;
      de      <= 1'b0;
      fs      <= 1'b0;
    end else if (vga.pix_ce) begin
      de1     <= de0;
      hs1     <= hs0;
      vs1     <= vs0;
      in_box1 <= in_box0;
      fs1     <= fs0;
      rgb     <= de1 ? (in_box1 ? BOX_COLOR : BG_COLOR) : '0;
      h_sync  <= hs1 ? HS_POL : ~HS_POL;
      v_sync  <= vs1 ? VS_POL : ~VS_POL;
      de      <= de1;
      fs      <= fs1;
    end
  end

  assign vga.pix_x       = h_cnt;
  assign vga.pix_y       = v_cnt;
  assign vga.po_vga_r    = rgb[3*COLOR_W-1 -: COLOR_W];
  assign vga.po_vga_g    = rgb[2*COLOR_W-1 -: COLOR_W];
  assign vga.po_vga_b    = rgb[COLOR_W-1:0];
  assign vga.po_h_sync   = h_sync;
  assign vga.po_v_sync   = v_sync;
  assign vga.po_de       = de;
  assign vga.frame_start = fs;

endmodule

// File: tb/tb_vga_timing_gen_param.sv
// Bench for vga_timing_gen_param: default, small and medium geometries against
// a pixel-index reference model plus hand-derived constants.
module tb_vga_timing_gen_param;

  // ---------------- clock / reset ----------------
  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  logic       rst_d;
  logic       rst_v [2];
  logic       ce    [2];
  logic [9:0] xm    [2];
  logic [9:0] ym    [2];

  vga_timing_gen_param_if #(.COLOR_W(4)) if_d ();
  vga_timing_gen_param_if #(.COLOR_W(4)) if_s ();
  vga_timing_gen_param_if #(.COLOR_W(4)) if_m ();

  assign if_d.pix_ce = 1'b1;
  assign if_d.x_move = 10'd0;
  assign if_d.y_move = 10'd0;
  assign if_s.pix_ce = ce[0];
  assign if_s.x_move = xm[0];
  assign if_s.y_move = ym[0];
  assign if_m.pix_ce = ce[1];
  assign if_m.x_move = xm[1];
  assign if_m.y_move = ym[1];

  vga_timing_gen_param dut_d (.sclk(sclk), .rst(rst_d), .vga(if_d));

  vga_timing_gen_param #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .COLOR_W(4), .BOX_SIZE(2),
    .BG_COLOR(12'h00F), .BOX_COLOR(12'hF00)
  ) dut_s (.sclk(sclk), .rst(rst_v[0]), .vga(if_s));

  vga_timing_gen_param #(
    .H_ACTIVE(32), .H_FP(4), .H_SYNC(4), .H_BP(4),
    .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(4), .BOX_SIZE(8),
    .BG_COLOR(12'h0A5), .BOX_COLOR(12'h3C3)
  ) dut_m (.sclk(sclk), .rst(rst_v[1]), .vga(if_m));

  logic [15:0] outp [2];
  logic [23:0] pixp [2];
  always_comb begin
    outp[0] = {if_s.po_vga_r, if_s.po_vga_g, if_s.po_vga_b,
               if_s.po_h_sync, if_s.po_v_sync, if_s.po_de, if_s.frame_start};
    outp[1] = {if_m.po_vga_r, if_m.po_vga_g, if_m.po_vga_b,
               if_m.po_h_sync, if_m.po_v_sync, if_m.po_de, if_m.frame_start};
    pixp[0] = {if_s.pix_y, if_s.pix_x};
    pixp[1] = {if_m.pix_y, if_m.pix_x};
  end

  // ---------------- reference model (index 0 = small, 1 = medium) ----------------
  int         p_ha [2] = '{8, 32};
  int         p_hf [2] = '{2, 4};
  int         p_hs [2] = '{2, 4};
  int         p_hb [2] = '{2, 4};
  int         p_va [2] = '{4, 24};
  int         p_vf [2] = '{1, 2};
  int         p_vs [2] = '{1, 2};
  int         p_vb [2] = '{1, 2};
  int         p_bs [2] = '{2, 8};
  logic       p_hpol [2] = '{1'b1, 1'b0};
  logic       p_vpol [2] = '{1'b0, 1'b0};
  logic [11:0] p_bg [2] = '{12'h00F, 12'h0A5};
  logic [11:0] p_bc [2] = '{12'hF00, 12'h3C3};

  int k [2];
  int bxa [2][256];
  int bya [2][256];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int h_tot(input int id);
    return p_ha[id] + p_hf[id] + p_hs[id] + p_hb[id];
  endfunction

  function automatic int v_tot(input int id);
    return p_va[id] + p_vf[id] + p_vs[id] + p_vb[id];
  endfunction

  // Expected pins after kk enabled ticks since reset: they show pixel kk-2.
  function automatic logic [15:0] model_out(input int id, input int kk);
    int s, h, v, f, bx, by, ht, ft;
    logic hp, vp, de_v, inb, hsa, vsa, fs_v;
    logic [11:0] rgb_v;
    hp = p_hpol[id];
    vp = p_vpol[id];
    if (kk < 2) return {12'h000, ~hp, ~vp, 2'b00};
    ht = h_tot(id);
    ft = ht * v_tot(id);
    s  = kk - 2;
    h  = s % ht;
    v  = (s / ht) % v_tot(id);
    f  = s / ft;
    if (f > 255) f = 255;
    bx = bxa[id][f];
    by = bya[id][f];
    de_v  = (h < p_ha[id]) && (v < p_va[id]);
    inb   = (h >= bx) && (h < bx + p_bs[id]) && (v >= by) && (v < by + p_bs[id]);
    hsa   = (h >= p_ha[id] + p_hf[id]) && (h < p_ha[id] + p_hf[id] + p_hs[id]);
    vsa   = (v >= p_va[id] + p_vf[id]) && (v < p_va[id] + p_vf[id] + p_vs[id]);
    fs_v  = (h == 0) && (v == 0);
    rgb_v = de_v ? (inb ? p_bc[id] : p_bg[id]) : 12'h000;
    return {rgb_v, hsa ? hp : ~hp, vsa ? vp : ~vp, de_v, fs_v};
  endfunction

  // ---------------- driver tasks ----------------
  // One sclk cycle: drive at negedge, update model, compare at next negedge.
  task automatic step(input int id, input logic c, input logic [9:0] x, input logic [9:0] y);
    int ht, ft, f, lim_x, lim_y, ex, ey;
    ht = h_tot(id);
    ft = ht * v_tot(id);
    ce[id] = c;
    xm[id] = x;
    ym[id] = y;
    if (c) begin
      if (k[id] % ft == ft - 1) begin
        f = (k[id] + 1) / ft;
        lim_x = p_ha[id] - p_bs[id];
        lim_y = p_va[id] - p_bs[id];
        if (f < 256) begin
          bxa[id][f] = (int'(x) > lim_x) ? lim_x : int'(x);
          bya[id][f] = (int'(y) > lim_y) ? lim_y : int'(y);
        end
      end
      k[id]++;
    end
    @(posedge sclk);
    @(negedge sclk);
    ex = k[id] % ht;
    ey = (k[id] / ht) % v_tot(id);
    check(id == 0 ? "s_out" : "m_out", 32'(outp[id]), 32'(model_out(id, k[id])));
    check(id == 0 ? "s_pix" : "m_pix", 32'(pixp[id]), 32'(ey * 4096 + ex));
  endtask

  task automatic do_reset(input int id);
    rst_v[id] = 1'b1;
    ce[id]    = 1'b0;
    k[id]     = 0;
    bxa[id][0] = 0;
    bya[id][0] = 0;
    @(negedge sclk);
    @(negedge sclk);
    check(id == 0 ? "s_rst_out" : "m_rst_out", 32'(outp[id]), 32'(model_out(id, 0)));
    check(id == 0 ? "s_rst_pix" : "m_rst_pix", 32'(pixp[id]), 32'd0);
    rst_v[id] = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    int         bx;
    int         by;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int first_fall, second_fall, de_cnt, guard, target;
    int min_h, max_h, min_v, max_v, red, s, h, v;
    int hs_cnt, vs_cnt, de_s, fs_cnt;
    logic prev_hs, c;

    // Medium geometry: box 8, visible 32x24, so clamps are 24 and 16
    tbl[0] = '{x: 10'd10,   y: 10'd5,    bx: 10, by: 5};
    tbl[1] = '{x: 10'd0,    y: 10'd0,    bx: 0,  by: 0};
    tbl[2] = '{x: 10'd1000, y: 10'd1000, bx: 24, by: 16};
    tbl[3] = '{x: 10'd24,   y: 10'd16,   bx: 24, by: 16};
    tbl[4] = '{x: 10'd25,   y: 10'd17,   bx: 24, by: 16};
    tbl[5] = '{x: 10'd3,    y: 10'd15,   bx: 3,  by: 15};

    rst_d = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rst_v[i] = 1'b1;
      ce[i]    = 1'b0;
      xm[i]    = '0;
      ym[i]    = '0;
    end
    @(negedge sclk);
    @(negedge sclk);

    // ---- default 640x480 geometry: directed timing checks ----
    check("d_rst_hs", 32'(if_d.po_h_sync), 32'd1);
    check("d_rst_vs", 32'(if_d.po_v_sync), 32'd1);
    check("d_rst_de", 32'(if_d.po_de), 32'd0);
    check("d_rst_rgb", 32'({if_d.po_vga_r, if_d.po_vga_g, if_d.po_vga_b}), 32'd0);
    rst_d = 1'b0;
    first_fall = -1;
    second_fall = -1;
    de_cnt = 0;
    prev_hs = 1'b1;
    for (int kk = 1; kk <= 1500; kk++) begin
      @(negedge sclk);
      if (prev_hs && !if_d.po_h_sync) begin
        if (first_fall < 0) first_fall = kk;
        else if (second_fall < 0) second_fall = kk;
      end
      prev_hs = if_d.po_h_sync;
      if (kk >= 2 && kk <= 801 && if_d.po_de) de_cnt++;
      if (kk == 2) begin
        check("d_fs_first", 32'(if_d.frame_start), 32'd1);
        check("d_rgb_box", 32'({if_d.po_vga_r, if_d.po_vga_g, if_d.po_vga_b}), 32'h00000F00);
      end
      if (kk == 3) check("d_fs_pulse", 32'(if_d.frame_start), 32'd0);
      if (kk == 34) check("d_rgb_bg", 32'({if_d.po_vga_r, if_d.po_vga_g, if_d.po_vga_b}), 32'h0000000F);
    end
    check("d_hs_fall1", 32'(first_fall), 32'd658);
    check("d_hs_fall2", 32'(second_fall), 32'd1458);
    check("d_de_line", 32'(de_cnt), 32'd640);
    check("d_pix_x", 32'(if_d.pix_x), 32'd700);
    check("d_pix_y", 32'(if_d.pix_y), 32'd1);
    check("d_vs_idle", 32'(if_d.po_v_sync), 32'd1);
    rst_d = 1'b1;

    // ---- medium geometry: table of box positions, random pix_ce and mid-frame moves ----
    do_reset(1);
    for (int e = 0; e < 6; e++) begin
      target = (k[1] / 1320 + 1) * 1320;
      guard = 0;
      while (k[1] < target && guard < 20000) begin
        step(1, ($urandom_range(0, 7) != 0), tbl[e].x, tbl[e].y);
        guard++;
      end
      min_h = 9999; max_h = -1; min_v = 9999; max_v = -1; red = 0;
      while (k[1] < target + 1320 + 2 && guard < 20000) begin
        c = ($urandom_range(0, 7) != 0);
        step(1, c, 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
        guard++;
        s = k[1] - 2;
        if (c && s >= target && s < target + 1320 && outp[1][15:4] == 12'h3C3) begin
          h = s % 44;
          v = (s / 44) % 30;
          red++;
          if (h < min_h) min_h = h;
          if (h > max_h) max_h = h;
          if (v < min_v) min_v = v;
          if (v > max_v) max_v = v;
        end
      end
      check("m_budget", 32'(guard < 20000), 32'd1);
      check("m_box_left", 32'(min_h), 32'(tbl[e].bx));
      check("m_box_right", 32'(max_h), 32'(tbl[e].bx + 7));
      check("m_box_top", 32'(min_v), 32'(tbl[e].by));
      check("m_box_bottom", 32'(max_v), 32'(tbl[e].by + 7));
      check("m_box_area", 32'(red), 32'd64);
    end
    ce[1] = 1'b0;

    // ---- small geometry, HS_POL=1, pix_ce on every other clock ----
    do_reset(0);
    check("s_hs_idle", 32'(if_s.po_h_sync), 32'd0);
    for (int i = 0; i < 40; i++)
      step(0, (i % 2 == 1), 10'($urandom_range(0, 15)), 10'($urandom_range(0, 7)));
    hs_cnt = 0; vs_cnt = 0; de_s = 0; fs_cnt = 0;
    for (int i = 40; i < 40 + 196; i++) begin
      step(0, (i % 2 == 1), 10'($urandom_range(0, 15)), 10'($urandom_range(0, 7)));
      if (if_s.po_h_sync) hs_cnt++;
      if (!if_s.po_v_sync) vs_cnt++;
      if (if_s.po_de) de_s++;
      if (if_s.frame_start) fs_cnt++;
    end
    check("s_hs_clocks", 32'(hs_cnt), 32'd28);
    check("s_vs_clocks", 32'(vs_cnt), 32'd28);
    check("s_de_clocks", 32'(de_s), 32'd64);
    check("s_fs_clocks", 32'(fs_cnt), 32'd2);

    // Asynchronous reset in the middle of a line
    for (int i = 0; i < 23; i++) step(0, 1'b1, 10'd5, 10'd1);
    #2;
    rst_v[0] = 1'b1;
    k[0] = 0;
    bxa[0][0] = 0;
    bya[0][0] = 0;
    #1;
    check("s_async_out", 32'(outp[0]), 32'h0004);
    check("s_async_pix", 32'(pixp[0]), 32'd0);
    @(negedge sclk);
    rst_v[0] = 1'b0;
    for (int i = 0; i < 300; i++)
      step(0, ($urandom_range(0, 3) != 0), 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
    ce[0] = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
